// File: rtl/piso_serializer_pkg.sv
// Shared types and defaults for the parallel-in / serial-out serializer.
// Holds the two-state FSM encoding and the default parallel word width.
package piso_serializer_pkg;

  localparam int DATA_W_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/piso_bit_cnt.sv
// Down-counter tracking how many bits of the current word remain after x_o.
// Loads on word acceptance, decrements per shifted bit, flags zero.
module piso_bit_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  // NOTE: clocked state is written with non-blocking assignments only, so every
  // flop samples the pre-edge values of its neighbours regardless of block order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/piso_serializer.sv
// Serializes DATA_W-bit words MSB first with a valid/ready input handshake
// and a shift enable that freezes the serial stream without repeating bits.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] pdata_i,
  input  logic              pvalid_i,
  output logic              pready_o,
  input  logic              ser_en_i,
  output logic              x_o,
  output logic              x_valid_o,
  output logic              last_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] sreg;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_zero;
  logic              last_q;
  logic              accept;
  logic              advance;

  // A new word can only enter when the current one leaves on this very edge.
  assign pready_o = (state == IDLE) | (last_q & ser_en_i);
  assign accept   = pvalid_i & pready_o;
  assign advance  = (state == SHIFT) & ser_en_i;

  // NOTE: every variable driven here gets a default first, so no path through
  // the case statement leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (advance && last_q) state_nxt = accept ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      sreg   <= '0;
      last_q <= 1'b0;
    end else begin
      state <= state_nxt;
      // Shifting out the LSB leaves sreg all-zero, which keeps x_o low in IDLE.
      if (accept) begin
        sreg <= pdata_i;
      end else if (advance) begin
        sreg <= {sreg[DATA_W-2:0], 1'b0};
      end
      if (accept) begin
        last_q <= 1'b0;
      end else if (advance) begin
        last_q <= (cnt == CNT_W'(1));
      end
    end
  end

  piso_bit_cnt #(
    .CNT_W (CNT_W)
  ) u_bit_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (accept),
    .load_val (CNT_W'(DATA_W - 1)),
    .dec      (advance & ~cnt_zero),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  assign x_o       = sreg[DATA_W-1];
  assign x_valid_o = (state == SHIFT);
  assign last_o    = last_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer (DATA_W = 4): cycle vector table,
// scoreboard of expected serial bits, and hand-written multi-cycle corner cases.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] pdata_i;
  logic       pvalid_i;
  logic       pready_o;
  logic       ser_en_i;
  logic       x_o;
  logic       x_valid_o;
  logic       last_o;

  piso_serializer #(.DATA_W(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pdata_i   (pdata_i),
    .pvalid_i  (pvalid_i),
    .pready_o  (pready_o),
    .ser_en_i  (ser_en_i),
    .x_o       (x_o),
    .x_valid_o (x_valid_o),
    .last_o    (last_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_bits   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic bit_v;
    logic last;
  } exp_bit_t;

  exp_bit_t sb_q[$];
  logic     sb_on = 1'b0;

  task automatic push_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) sb_q.push_back('{bit_v: w[i], last: (i == 0)});
  endtask

  // A bit is consumed when it is valid and the enable lets it shift this edge.
  always @(negedge clk) begin
    #1;
    if (sb_on && reset_n && x_valid_o && ser_en_i) begin
      n_bits++;
      if (sb_q.size() == 0) begin
        check("sb_unexpected_bit", 32'(x_o), 32'hx);
      end else begin
        exp_bit_t e;
        e = sb_q.pop_front();
        check("sb_bit", 32'(x_o), 32'(e.bit_v));
        check("sb_last", 32'(last_o), 32'(e.last));
      end
    end
  end

  // Downstream 4-bit serial-in shift register fed by the serializer.
  logic [3:0] sr_o;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) sr_o <= 4'h0;
    else if (x_valid_o && ser_en_i) sr_o <= {sr_o[2:0], x_o};
  end

  typedef struct {
    logic       pvalid;
    logic       en;
    logic [3:0] d;
    logic       x;
    logic       xv;
    logic       last;
    logic       pr;
  } vec_t;

  vec_t tbl[16];

  task automatic send(input logic [3:0] w);
    @(negedge clk);
    pvalid_i = 1'b1; pdata_i = w; ser_en_i = 1'b1;
    push_word(w);
    @(negedge clk);
    pvalid_i = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 20) begin
      @(negedge clk); #2;
      k++;
    end
    check("drain_timeout", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic check_idle(input string name);
    check({name, "_x"},    32'(x_o),       32'd0);
    check({name, "_xv"},   32'(x_valid_o), 32'd0);
    check({name, "_last"}, 32'(last_o),    32'd0);
  endtask

  initial begin
    int nb0;

    // A then C/3 back to back, pdata changing while not ready.
    tbl[0]  = '{1'b1, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 4'hC, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1};

    reset_n = 1'b0; pvalid_i = 1'b1; pdata_i = 4'hF; ser_en_i = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_idle("reset");
    check("reset_pready", 32'(pready_o), 32'd1);
    @(negedge clk);
    pvalid_i = 1'b0; reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pvalid_i = tbl[i].pvalid; ser_en_i = tbl[i].en; pdata_i = tbl[i].d;
      #1;
      check($sformatf("tbl%0d_x", i),    32'(x_o),       32'(tbl[i].x));
      check($sformatf("tbl%0d_xv", i),   32'(x_valid_o), 32'(tbl[i].xv));
      check($sformatf("tbl%0d_last", i), 32'(last_o),    32'(tbl[i].last));
      check($sformatf("tbl%0d_pr", i),   32'(pready_o),  32'(tbl[i].pr));
    end
    pvalid_i = 1'b0;
    sb_on = 1'b1;

    // Word 9, enable dropped for three cycles after the second bit.
    nb0 = n_bits;
    send(4'h9);
    @(negedge clk);
    @(negedge clk);
    ser_en_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      check("frz_x",  32'(x_o),       32'd0);
      check("frz_xv", 32'(x_valid_o), 32'd1);
      check("frz_pr", 32'(pready_o),  32'd0);
    end
    @(negedge clk);
    ser_en_i = 1'b1;
    drain();
    @(negedge clk); #2;
    check("frz_bits", 32'(n_bits - nb0), 32'd4);
    check_idle("frz_end");

    // Reset pulse during the third bit of F aborts the word.
    @(negedge clk);
    pvalid_i = 1'b1; pdata_i = 4'hF; ser_en_i = 1'b1;
    push_word(4'hF);
    @(negedge clk);
    pvalid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_xv", 32'(x_valid_o), 32'd0);
    check("abort_pr", 32'(pready_o),  32'd1);
    sb_q.delete();
    repeat (2) begin
      @(negedge clk); #1;
      check("abort_hold_xv", 32'(x_valid_o), 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_idle("abort_rel");
    send(4'h1);
    drain();

    // New valid while busy must not disturb the word in flight.
    @(negedge clk);
    pvalid_i = 1'b1; pdata_i = 4'h5; ser_en_i = 1'b1;
    push_word(4'h5);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      pvalid_i = 1'b1; pdata_i = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    pvalid_i = 1'b0;
    drain();
    @(negedge clk); #2;
    check_idle("busy_end");

    // End to end through the downstream shift register.
    send(4'h6);
    drain();
    @(negedge clk); #2;
    check("sr_o", 32'(sr_o), 32'h6);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout actual=%0t required=<20000", $time);
    $fatal(1);
  end

endmodule
